// File: rtl/mean_pkg.sv
// Shared definitions for the mean_avg window feeder: default widths,
// window-mode encodings, FSM state type and the running-sum width helper.
package mean_pkg;

    localparam int WID_DEF = 16;
    localparam int TAPS    = 8;

    localparam logic MODE_SLIDE = 1'b0;
    localparam logic MODE_BLOCK = 1'b1;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Eight WID-bit values sum into at most WID+3 bits.
    function automatic int SUM_WID(input int wid);
        return wid + 3;
    endfunction

endpackage

// File: rtl/mean_tap_shift.sv
// Enable shift register holding the tap window. Slot 0 takes the newest
// sample; the oldest slot is exposed as "dropped" so a caller can track
// the value about to leave the window.
module mean_tap_shift #(
    parameter int WID  = 16,
    parameter int TAPS = 8
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      en,
    input  logic [WID-1:0]            din,
    output logic [TAPS-1:0][WID-1:0]  taps,
    output logic [WID-1:0]            dropped
);

    // Clear has priority over shifting; otherwise shift din in at slot 0.
    always_ff @(posedge clk) begin
        if (clr) begin
            taps <= '0;
        end else if (en) begin
            taps <= {taps[TAPS-2:0], din};
        end
    end

    assign dropped = taps[TAPS-1];

endmodule

// File: rtl/mean_window_feeder.sv
// mean_window_feeder: turns a valid/ready sample stream into an 8-tap
// parallel window (out_000 newest .. out_007 oldest) with a window-valid
// handshake for mean_avg. Supports sliding and block (non-overlapping)
// windows. Optional running sum of the taps when the macro
// MEAN_WINDOW_FEEDER_SUM_EN is defined.
module mean_window_feeder #(
    parameter int WID  = mean_pkg::WID_DEF,
    parameter int TAPS = mean_pkg::TAPS
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [WID-1:0] s_data,
    input  logic           mode,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [WID-1:0] out_000,
    output logic [WID-1:0] out_001,
    output logic [WID-1:0] out_002,
    output logic [WID-1:0] out_003,
    output logic [WID-1:0] out_004,
    output logic [WID-1:0] out_005,
    output logic [WID-1:0] out_006,
    output logic [WID-1:0] out_007,
    output logic [3:0]     fill
`ifdef MEAN_WINDOW_FEEDER_SUM_EN
    ,
    output logic [mean_pkg::SUM_WID(WID)-1:0] out_sum
`endif
);

    import mean_pkg::*;

    // The port list carries exactly eight taps.
    if (TAPS != mean_pkg::TAPS) begin : g_taps_check
        $error("mean_window_feeder: TAPS must be 8");
    end

    localparam logic [3:0] FULL = 4'(TAPS);

    state_t                     state_q, state_d;
    logic [3:0]                 fill_q, fill_d;
    logic                       mode_q;
    logic                       s_acc;
    logic                       w_acc;
    logic                       clr;
    logic [TAPS-1:0][WID-1:0]   taps;
    logic [WID-1:0]             dropped;

    // Saturating fill increment.
    function automatic logic [3:0] fill_inc(input logic [3:0] f);
        return (f >= FULL) ? FULL : f + 4'd1;
    endfunction

    assign out_valid = (state_q == HOLD);
    assign s_ready   = rst & ~flush & (~out_valid | out_ready);
    assign s_acc     = s_valid & s_ready;
    assign w_acc     = out_valid & out_ready;
    assign clr       = ~rst | flush;
    assign fill      = fill_q;

    mean_tap_shift #(
        .WID  (WID),
        .TAPS (TAPS)
    ) u_shift (
        .clk     (clk),
        .clr     (clr),
        .en      (s_acc),
        .din     (s_data),
        .taps    (taps),
        .dropped (dropped)
    );

    assign out_000 = taps[0];
    assign out_001 = taps[1];
    assign out_002 = taps[2];
    assign out_003 = taps[3];
    assign out_004 = taps[4];
    assign out_005 = taps[5];
    assign out_006 = taps[6];
    assign out_007 = taps[7];

    // Next-state and fill: flush wins, then FILL/HOLD handshake rules.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        if (flush) begin
            state_d = FILL;
            fill_d  = 4'd0;
        end else begin
            case (state_q)
                FILL: begin
                    if (s_acc) begin
                        fill_d = fill_inc(fill_q);
                        if (fill_d == FULL) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_acc) begin
                        if (mode_q == MODE_SLIDE) begin
                            // A sample in the handoff cycle presents the next
                            // sliding window straight away.
                            if (!s_acc) begin
                                state_d = FILL;
                            end
                        end else begin
                            state_d = FILL;
                            fill_d  = s_acc ? 4'd1 : 4'd0;
                        end
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    // State and fill registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FILL;
            fill_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    // Window mode only changes at an idle point (empty and nothing pending).
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q <= MODE_SLIDE;
        end else if (fill_q == 4'd0 && !out_valid) begin
            mode_q <= mode;
        end
    end

`ifdef MEAN_WINDOW_FEEDER_SUM_EN
    localparam int SW = SUM_WID(WID);

    logic [SW-1:0] sum_q, sum_d;

    // Running tap sum. The oldest tap is subtracted only once the window is
    // full; before that it is a leftover from a previous block window and
    // was never added.
    always_comb begin
        sum_d = sum_q;
        if (flush) begin
            sum_d = '0;
        end else if (w_acc && mode_q == MODE_BLOCK) begin
            sum_d = s_acc ? SW'(s_data) : '0;
        end else if (s_acc) begin
            sum_d = sum_q + SW'(s_data) - ((fill_q == FULL) ? SW'(dropped) : '0);
        end
    end

    // Sum register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign out_sum = sum_q;
`else
    logic unused_dropped;
    assign unused_dropped = ^dropped;
`endif

endmodule

// File: tb/tb_mean_window_feeder.sv
// Directed, table-driven bench for mean_window_feeder with hand-written
// sequences for reset hold and the block-mode two-window stream.
module tb_mean_window_feeder;

    localparam int WID = 16;
    localparam int SW  = WID + 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [WID-1:0] s_data = '0;
    logic           mode = 1'b0;
    logic           flush = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [WID-1:0] out_000, out_001, out_002, out_003;
    logic [WID-1:0] out_004, out_005, out_006, out_007;
    logic [3:0]     fill;
`ifdef MEAN_WINDOW_FEEDER_SUM_EN
    logic [SW-1:0]  out_sum;
`endif

    always #5 clk = ~clk;

    mean_window_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .mode      (mode),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_000   (out_000),
        .out_001   (out_001),
        .out_002   (out_002),
        .out_003   (out_003),
        .out_004   (out_004),
        .out_005   (out_005),
        .out_006   (out_006),
        .out_007   (out_007),
        .fill      (fill)
`ifdef MEAN_WINDOW_FEEDER_SUM_EN
        ,
        .out_sum   (out_sum)
`endif
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        sv;
        logic [15:0] d;
        logic        m;
        logic        fl;
        logic        ordy;
        logic        esr;
        logic        eov;
        logic [3:0]  ef;
        logic [15:0] e0;
        logic [15:0] e7;
        logic [18:0] es;
        bit          zero;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void add(input string nm, input int r, input int sv, input int d,
                                input int m, input int fl, input int ordy, input int esr,
                                input int eov, input int ef, input int e0, input int e7,
                                input int es);
        vec_t v;
        v.name = nm;   v.rst = 1'(r);  v.sv = 1'(sv);   v.d = 16'(d);
        v.m = 1'(m);   v.fl = 1'(fl);  v.ordy = 1'(ordy);
        v.esr = 1'(esr); v.eov = 1'(eov); v.ef = 4'(ef);
        v.e0 = 16'(e0);  v.e7 = 16'(e7);  v.es = 19'(es);
        v.zero = 1'b0;
        vecs.push_back(v);
    endfunction

    function automatic void mark_zero();
        vecs[vecs.size()-1].zero = 1'b1;
    endfunction

    task automatic chk_taps_zero(input string nm);
        logic [WID-1:0] t [8];
        t = '{out_000, out_001, out_002, out_003, out_004, out_005, out_006, out_007};
        for (int k = 0; k < 8; k++) chk($sformatf("%s tap%0d", nm, k), 32'(t[k]), 32'd0);
    endtask

    // Applies inputs just after an edge, checks s_ready before the next edge
    // and the registered outputs just after it.
    task automatic run_vecs();
        foreach (vecs[i]) begin
            rst = vecs[i].rst;   s_valid = vecs[i].sv; s_data = vecs[i].d;
            mode = vecs[i].m;    flush = vecs[i].fl;   out_ready = vecs[i].ordy;
            #1;
            chk({vecs[i].name, " s_ready"}, 32'(s_ready), 32'(vecs[i].esr));
            @(posedge clk); #1;
            chk({vecs[i].name, " out_valid"}, 32'(out_valid), 32'(vecs[i].eov));
            chk({vecs[i].name, " fill"}, 32'(fill), 32'(vecs[i].ef));
            chk({vecs[i].name, " out_000"}, 32'(out_000), 32'(vecs[i].e0));
            chk({vecs[i].name, " out_007"}, 32'(out_007), 32'(vecs[i].e7));
`ifdef MEAN_WINDOW_FEEDER_SUM_EN
            if (vecs[i].eov) chk({vecs[i].name, " out_sum"}, 32'(out_sum), 32'(vecs[i].es));
`endif
            if (vecs[i].zero) chk_taps_zero(vecs[i].name);
        end
        vecs.delete();
    endtask

    initial begin
        int nwin;
        @(posedge clk); #1;

        // Reset held for 10 cycles with a sample offered.
        rst = 1'b0; s_valid = 1'b1; s_data = 16'd99; out_ready = 1'b1; mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("reset s_ready", 32'(s_ready), 32'd0);
            @(posedge clk); #1;
            chk("reset out_valid", 32'(out_valid), 32'd0);
            chk("reset fill", 32'(fill), 32'd0);
        end
        chk_taps_zero("reset");

        // Sliding fill, next window, backpressure, flush into block idle.
        add("release", 1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            add("slide_fill", 1, 1, 10 + i, 0, 0, 1,  1, (i == 7), i + 1, 10 + i, (i == 7) ? 10 : 0, 108);
        add("slide_next", 1, 1, 18, 0, 0, 1,  1, 1, 8, 18, 11, 116);
        for (int i = 0; i < 5; i++)
            add("backpressure", 1, 1, 19, 0, 0, 0,  0, 1, 8, 18, 11, 116);
        add("bp_release", 1, 1, 18, 0, 0, 1,  1, 1, 8, 18, 12, 123);
        add("slide_idle", 1, 0, 0, 0, 0, 1,  1, 0, 8, 18, 12, 0);
        add("slide_refill", 1, 1, 20, 0, 0, 1,  1, 1, 8, 20, 13, 131);
        add("flush_hold", 1, 1, 77, 1, 1, 1,  0, 0, 0, 0, 0, 0); mark_zero();
        add("idle_block", 1, 0, 0, 1, 0, 1,  1, 0, 0, 0, 0, 0);
        run_vecs();

        // Block mode: 0..15 streamed back to back gives exactly two windows.
        nwin = 0;
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1; s_data = 16'(i); out_ready = 1'b1; mode = 1'b1; flush = 1'b0;
            #1;
            chk("block s_ready", 32'(s_ready), 32'd1);
            @(posedge clk); #1;
            if (out_valid) nwin++;
            chk($sformatf("block out_valid %0d", i), 32'(out_valid), 32'((i == 7) || (i == 15)));
            if (i == 7 || i == 15) begin
                chk("block win out_000", 32'(out_000), 32'(i));
                chk("block win out_007", 32'(out_007), 32'(i - 7));
`ifdef MEAN_WINDOW_FEEDER_SUM_EN
                chk("block win out_sum", 32'(out_sum), (i == 7) ? 32'd28 : 32'd92);
`endif
            end
            if (i == 8) chk("block fill after handoff", 32'(fill), 32'd1);
        end
        s_valid = 1'b0;
        @(posedge clk); #1;
        chk("block tail out_valid", 32'(out_valid), 32'd0);
        chk("block tail fill", 32'(fill), 32'd0);
        chk("block window count", 32'(nwin), 32'd2);

        // Flush mid-window, mode change mid-stream, reset mid-window.
        for (int i = 0; i < 5; i++)
            add("flush_pre", 1, 1, 30 + i, 0, 0, 1,  1, 0, i + 1, 30 + i, 9 + i, 0);
        add("flush_mid", 1, 1, 35, 0, 1, 1,  0, 0, 0, 0, 0, 0); mark_zero();
        for (int i = 0; i < 8; i++)
            add("after_flush", 1, 1, 40 + i, 0, 0, 1,  1, (i == 7), i + 1, 40 + i, (i == 7) ? 40 : 0, 348);
        add("flush_hold_nordy", 1, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            add("mode_slide", 1, 1, 50 + i, 0, 0, 1,  1, 0, i + 1, 50 + i, 0, 0);
        for (int i = 0; i < 5; i++)
            add("mode_toggle", 1, 1, 53 + i, 1, 0, 1,  1, (i == 4), 4 + i, 53 + i, (i == 4) ? 50 : 0, 428);
        add("still_slide", 1, 1, 58, 1, 0, 1,  1, 1, 8, 58, 51, 436);
        add("flush2", 1, 0, 0, 1, 1, 1,  0, 0, 0, 0, 0, 0); mark_zero();
        add("idle2", 1, 0, 0, 1, 0, 1,  1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            add("block2", 1, 1, 60 + i, 1, 0, 1,  1, (i == 7), i + 1, 60 + i, (i == 7) ? 60 : 0, 508);
        add("block2_handoff", 1, 1, 68, 1, 0, 1,  1, 0, 1, 68, 61, 0);
        add("mid_rst_a", 1, 1, 70, 1, 0, 1,  1, 0, 2, 70, 62, 0);
        add("mid_rst_b", 1, 1, 71, 1, 0, 1,  1, 0, 3, 71, 63, 0);
        add("reset_mid", 0, 1, 72, 1, 0, 1,  0, 0, 0, 0, 0, 0); mark_zero();
        add("release2", 1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
        run_vecs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mean_window_feeder.md
Name: mean_window_feeder

Overview:
- Producer side of the mean_avg parallel-tap interface. Accepts a serial sample stream on a valid/ready handshake and assembles it into an 8-tap window, out_000..out_007, with a window-valid handshake. mean_avg consumes that window.
- Sits between a streaming sample source and mean_avg. It replaces the bench-style direct driving of the eight tap inputs.

Parameters:
- WID, 16, sample and tap width in bits.
- TAPS, 8, window depth. The port list fixes this value; an elaboration check must fail on any other value.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset; 0 = reset, sampled on rising clk.
- s_valid  input  1  an input sample is offered.
- s_ready  output  1  the feeder can accept a sample this cycle.
- s_data  input  WID  input sample.
- mode  input  1  0 = sliding window, 1 = block (non-overlapping) window; latched only when idle.
- flush  input  1  single-cycle request to discard the window.
- out_valid  output  1  window out_000..out_007 is complete and stable.
- out_ready  input  1  the consumer accepts the window.
- out_000..out_007  output  WID each  window taps; out_000 = newest, out_007 = oldest.
- fill  output  4  count of valid taps, 0..8.

Behaviour:
- Reset (rst=0 at an edge): all taps = 0, fill = 0, out_valid = 0, mode_q = 0, s_ready = 0 during reset. Reset mid-window discards the window without producing output.
- Accept rules:
  - Sample accept = s_valid & s_ready.
  - Window accept = out_valid & out_ready.
  - s_ready = rst & !flush & (!out_valid | out_ready), so a pending window can be handed off and refilled in the same cycle.
- Shift on each accepted sample: out_000 <= s_data; out_k <= out_(k-1) for k = 1..7. The value shifted out of out_007 is dropped. Registered; the new taps are visible from the edge that accepts the sample (1-cycle latency).
- fill:
  - Increments on sample accept and saturates at 8.
  - In block mode it resets as described below.
- mode_q:
  - Loads from mode on any edge where fill == 0 and out_valid == 0.
  - A mid-window change of mode is ignored until the next idle point, which is reached by flush, reset, or a block-mode handoff.
- State machine, two states:
  - FILL (out_valid = 0): accept samples. When the accepted sample makes fill reach 8, go to HOLD and set out_valid = 1 on that same edge.
  - HOLD (out_valid = 1): taps are frozen unless out_ready = 1.
- HOLD with out_ready = 1, sliding mode (mode_q = 0):
  - If a sample is accepted in the same cycle, shift and stay in HOLD with out_valid = 1; the new window is presented.
  - Otherwise go to FILL with fill staying at 8, so the next accepted sample immediately re-enters HOLD.
- HOLD with out_ready = 1, block mode (mode_q = 1):
  - A simultaneous sample becomes tap 1 of the next window: fill = 1, state = FILL.
  - Otherwise fill = 0, state = FILL.
- flush:
  - Highest priority after reset.
  - Next edge: fill = 0, out_valid = 0, taps = 0.
  - Any s_valid in the flush cycle is not accepted (s_ready = 0).
  - If flush coincides with out_ready, the window counts as consumed: the consumer saw out_valid & out_ready.
- No data arithmetic beyond the tap shift. fill is unsigned 4-bit.

Optional Feature:
- Macro: MEAN_WINDOW_FEEDER_SUM_EN.
- Defined:
  - Adds output out_sum, WID+3 bits, unsigned: the exact sum of the 8 taps.
  - Maintained incrementally: sum + s_data - out_007 on each shift.
  - Cleared to 0 by reset, by flush, and by a block-mode handoff (loaded with s_data if a sample arrives in that cycle).
  - Valid whenever out_valid = 1.
- Undefined: the port and the accumulator are absent; all other behaviour is identical.

Decomposition:
- Shared package mean_pkg:
  - WID_DEF = 16 and TAPS = 8.
  - Mode encodings MODE_SLIDE = 0 and MODE_BLOCK = 1.
  - FSM state type, values FILL and HOLD.
  - Sum width function SUM_WID(WID) = WID+3.
- One natural sub-module, mean_tap_shift: an 8-stage WID-bit enable shift register with synchronous clear, exposing all taps and the dropped oldest value. The FSM, handshake and fill counter stay in the top module.

Test Plan:
1. Reset: hold rst=0 for 10 cycles with s_valid=1 -> s_ready=0, out_valid=0, fill=0, all taps 0. Release -> s_ready=1.
2. Sliding fill, out_ready=1:
   - Send 10..17 on consecutive cycles -> out_valid rises on the edge accepting 17, with out_000=17 and out_007=10 (out_sum=108 if the macro is defined).
   - Send 18 -> out_000=18, out_007=11, out_valid stays 1 (out_sum=116).
3. Backpressure: window full and out_ready=0 for 5 cycles with s_valid=1 -> s_ready=0 and taps unchanged. Raise out_ready with 18 offered -> accepted in the same cycle and the new window is presented next edge.
4. Block mode: mode=1 from idle.
   - Send 0..15 with out_ready=1 -> exactly two windows: (7..0) then (15..8), each out_valid for 1 cycle.
   - Windows do not overlap; fill reads 1 on the cycle after a handoff that carried a sample.
5. Flush mid-window: after 5 samples, pulse flush with s_valid=1 -> that sample is not accepted; next cycle fill=0 and taps=0. Eight more samples -> a clean window.
6. Mode change mid-stream: mode toggles to 1 after 3 sliding samples -> behaviour remains sliding. After a flush, block behaviour applies.
